fp_classify_pipe: RTL and testbench

Multi-lane, pipelined floating-point classifier with valid/ready handshakes on both sides. Each beat carries `LANES` packed operands of a parametrised format. Every enabled lane gets a 10-bit one-hot class mask that separates sign, subnormal and signalling/quiet NaN. The block also keeps a sticky signalling-NaN flag and a saturating NaN counter, and sits between an operand-fetch stage and FP exception/dispatch logic.

---
 rtl/fp_class_pkg.sv | 34 +++
 rtl/fp_class_lane.sv | 62 ++++++
 rtl/fp_classify_pipe.sv | 175 +++++++++++++++++
 tb/tb_fp_classify_pipe.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_class_pkg.sv
// -----------------------------------------------------------------------------
// fp_class_pkg
// Shared definitions for the floating-point classifier:
//   CLASS_W        : width of the per-lane one-hot class mask
//   fp_class_bit_e : bit index of each class inside the mask
//   fp_class_t     : per-lane class mask type
//   buf_state_e    : occupancy states of the 2-entry output skid buffer
// -----------------------------------------------------------------------------
package fp_class_pkg;

   localparam int CLASS_W = 10;

   typedef logic [CLASS_W-1:0] fp_class_t;

   typedef enum logic [3:0] {
      CLS_NEG_INF  = 4'd0,
      CLS_NEG_NORM = 4'd1,
      CLS_NEG_SUB  = 4'd2,
      CLS_NEG_ZERO = 4'd3,
      CLS_POS_ZERO = 4'd4,
      CLS_POS_SUB  = 4'd5,
      CLS_POS_NORM = 4'd6,
      CLS_POS_INF  = 4'd7,
      CLS_SNAN     = 4'd8,
      CLS_QNAN     = 4'd9
   } fp_class_bit_e;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_TWO   = 2'd2
   } buf_state_e;

endpackage : fp_class_pkg

// File: rtl/fp_class_lane.sv
// -----------------------------------------------------------------------------
// fp_class_lane
// Combinational classifier for one packed floating-point operand.
// Ports:
//   op_i    : operand {sign (optional), exponent, mantissa}
//   class_o : one-hot class mask (see fp_class_bit_e)
// With SIGN_W = 0 there is no sign field and every operand is positive.
// -----------------------------------------------------------------------------
module fp_class_lane
   import fp_class_pkg::*;
#(
   parameter  int SIGN_W = 1,
   parameter  int EXPO_W = 8,
   parameter  int MANT_W = 23,
   localparam int FP_W   = SIGN_W + EXPO_W + MANT_W
) (
   input  logic [FP_W-1:0] op_i,
   output fp_class_t       class_o
);

   logic              sign;
   logic [EXPO_W-1:0] expo;
   logic [MANT_W-1:0] mant;

   assign expo = op_i[MANT_W +: EXPO_W];
   assign mant = op_i[MANT_W-1:0];

   if (SIGN_W > 0) begin : g_sign
      assign sign = op_i[FP_W-1];
   end else begin : g_no_sign
      assign sign = 1'b0;
   end

   // NOTE: every output of a combinational block gets a default before any
   // branch, so no path through the block leaves it unassigned (no latch).
   always_comb begin
      class_o = '0;
      if (&expo) begin
         if (mant == '0) begin
            if (sign) class_o[CLS_NEG_INF] = 1'b1;
            else      class_o[CLS_POS_INF] = 1'b1;
         end else if (mant[MANT_W-1]) begin
            // NaN classes ignore the sign; the mantissa MSB is the quiet bit.
            class_o[CLS_QNAN] = 1'b1;
         end else begin
            class_o[CLS_SNAN] = 1'b1;
         end
      end else if (expo == '0) begin
         if (mant == '0) begin
            if (sign) class_o[CLS_NEG_ZERO] = 1'b1;
            else      class_o[CLS_POS_ZERO] = 1'b1;
         end else begin
            if (sign) class_o[CLS_NEG_SUB] = 1'b1;
            else      class_o[CLS_POS_SUB] = 1'b1;
         end
      end else begin
         if (sign) class_o[CLS_NEG_NORM] = 1'b1;
         else      class_o[CLS_POS_NORM] = 1'b1;
      end
   end

endmodule : fp_class_lane

// File: rtl/fp_classify_pipe.sv
// -----------------------------------------------------------------------------
// fp_classify_pipe
// Multi-lane pipelined floating-point classifier with valid/ready on both
// sides, a 2-entry skid buffer, a sticky sNaN flag and a saturating NaN count.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   in_valid     : input beat valid          in_ready   : buffer not full
//   in_data      : LANES packed operands     in_lane_en : per-lane enable
//   out_valid    : head entry present        out_ready  : consumer accepts
//   out_class    : per-lane class masks      out_lane_en: forwarded enables
//   clr          : synchronous clear of the statistics
//   sticky_snan  : an accepted enabled lane was an sNaN
//   nan_cnt      : saturating count of accepted enabled NaN lanes
// -----------------------------------------------------------------------------
module fp_classify_pipe
   import fp_class_pkg::*;
#(
   parameter  int SIGN_W = 1,
   parameter  int EXPO_W = 8,
   parameter  int MANT_W = 23,
   parameter  int LANES  = 4,
   parameter  int CNT_W  = 16,
   localparam int FP_W   = SIGN_W + EXPO_W + MANT_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANES*FP_W-1:0]    in_data,
   input  logic [LANES-1:0]         in_lane_en,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANES*CLASS_W-1:0] out_class,
   output logic [LANES-1:0]         out_lane_en,
   input  logic                     clr,
   output logic                     sticky_snan,
   output logic [CNT_W-1:0]         nan_cnt
);

   // Counter arithmetic is done one bit wider than the larger operand so the
   // saturation test can see the overflow.
   localparam int ADD_W = $clog2(LANES + 1);
   localparam int SUM_W = ((CNT_W > ADD_W) ? CNT_W : ADD_W) + 1;
   localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

   typedef struct packed {
      logic [LANES*CLASS_W-1:0] cls;
      logic [LANES-1:0]         lane_en;
   } entry_t;

   // ---------------------------------------------------------------- lanes
   fp_class_t                lane_class [LANES];
   logic [LANES*CLASS_W-1:0] beat_class;
   logic [LANES-1:0]         lane_nan;
   logic [LANES-1:0]         lane_snan;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      fp_class_lane #(
         .SIGN_W (SIGN_W),
         .EXPO_W (EXPO_W),
         .MANT_W (MANT_W)
      ) u_lane (
         .op_i    (in_data[i*FP_W +: FP_W]),
         .class_o (lane_class[i])
      );

      // Disabled lanes are squashed here so they reach neither the buffer
      // nor the statistics.
      assign beat_class[i*CLASS_W +: CLASS_W] = in_lane_en[i] ? lane_class[i] : '0;
      assign lane_nan[i]  = in_lane_en[i] & (lane_class[i][CLS_SNAN] | lane_class[i][CLS_QNAN]);
      assign lane_snan[i] = in_lane_en[i] & lane_class[i][CLS_SNAN];
   end

   // ---------------------------------------------------------- skid buffer
   buf_state_e state_q, state_d;
   entry_t     head_q, head_d;
   entry_t     tail_q, tail_d;
   entry_t     new_entry;
   logic       push, pop;

   assign new_entry = '{cls: beat_class, lane_en: in_lane_en};

   // Both flags come straight from the registered occupancy, so out_ready has
   // no combinational path to in_ready.
   assign in_ready  = (state_q != BUF_TWO);
   assign out_valid = (state_q != BUF_EMPTY);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (state_q)
         BUF_EMPTY: begin
            if (push) begin
               head_d  = new_entry;
               state_d = BUF_ONE;
            end
         end
         BUF_ONE: begin
            if (push && pop) begin
               head_d = new_entry;
            end else if (push) begin
               tail_d  = new_entry;
               state_d = BUF_TWO;
            end else if (pop) begin
               state_d = BUF_EMPTY;
            end
         end
         BUF_TWO: begin
            if (pop) begin
               head_d  = tail_q;
               state_d = BUF_ONE;
            end
         end
         default: state_d = BUF_EMPTY;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of process evaluation order.
   // NOTE: the buffer entries are reset, not just the occupancy, because the
   // head entry drives out_class/out_lane_en, which must read zero after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= BUF_EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   assign out_class   = head_q.cls;
   assign out_lane_en = head_q.lane_en;

   // ----------------------------------------------------------- statistics
   logic [ADD_W-1:0] nan_add;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
   logic [SUM_W-1:0] cnt_sum;
   logic             sticky_q, sticky_d;

   always_comb begin
      nan_add = '0;
      for (int i = 0; i < LANES; i++) begin
         nan_add = nan_add + ADD_W'(lane_nan[i]);
      end
   end

   // clr discards the old value but the beat accepted in the same cycle
   // still counts.
   always_comb begin
      cnt_base = clr ? '0 : cnt_q;
      cnt_sum  = SUM_W'(cnt_base) + (push ? SUM_W'(nan_add) : '0);
      cnt_d    = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
      sticky_d = (clr ? 1'b0 : sticky_q) | (push & (|lane_snan));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         sticky_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         sticky_q <= sticky_d;
      end
   end

   assign nan_cnt     = cnt_q;
   assign sticky_snan = sticky_q;

endmodule : fp_classify_pipe

// File: tb/tb_fp_classify_pipe.sv
// -----------------------------------------------------------------------------
// tb_fp_classify_pipe
// Self-checking bench for fp_classify_pipe: fp32 x 4 lanes main instance with
// a scoreboard model, plus a CNT_W=2 instance (saturation) and a 15-bit
// unsigned-format instance (small format decode).
// -----------------------------------------------------------------------------
module tb_fp_classify_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------- main instance
   logic         in_valid = 1'b0, in_ready;
   logic [127:0] in_data = '0;
   logic [3:0]   in_lane_en = '0;
   logic         out_valid, out_ready = 1'b1;
   logic [39:0]  out_class;
   logic [3:0]   out_lane_en;
   logic         clr = 1'b0, sticky_snan;
   logic [15:0]  nan_cnt;

   fp_classify_pipe #(.SIGN_W(1), .EXPO_W(8), .MANT_W(23), .LANES(4), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_lane_en(in_lane_en), .out_valid(out_valid), .out_ready(out_ready),
      .out_class(out_class), .out_lane_en(out_lane_en), .clr(clr),
      .sticky_snan(sticky_snan), .nan_cnt(nan_cnt)
   );

   // --------------------------------------------- saturation instance (CNT_W=2)
   logic         in_valid2 = 1'b0, in_ready2;
   logic [127:0] in_data2 = '0;
   logic [3:0]   in_lane_en2 = '0;
   logic         out_valid2;
   logic [39:0]  out_class2;
   logic [3:0]   out_lane_en2;
   logic         sticky_snan2;
   logic [1:0]   nan_cnt2;

   fp_classify_pipe #(.SIGN_W(1), .EXPO_W(8), .MANT_W(23), .LANES(4), .CNT_W(2)) u_dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
      .in_lane_en(in_lane_en2), .out_valid(out_valid2), .out_ready(1'b1),
      .out_class(out_class2), .out_lane_en(out_lane_en2), .clr(1'b0),
      .sticky_snan(sticky_snan2), .nan_cnt(nan_cnt2)
   );

   // ------------------------------------------ small format (no sign, 5/10)
   logic         in_valid3 = 1'b0, in_ready3;
   logic [14:0]  in_data3 = '0;
   logic         out_valid3;
   logic [9:0]   out_class3;
   logic [0:0]   out_lane_en3;
   logic         sticky_snan3;
   logic [15:0]  nan_cnt3;

   fp_classify_pipe #(.SIGN_W(0), .EXPO_W(5), .MANT_W(10), .LANES(1), .CNT_W(16)) u_dut_small (
      .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
      .in_lane_en(1'b1), .out_valid(out_valid3), .out_ready(1'b1),
      .out_class(out_class3), .out_lane_en(out_lane_en3), .clr(1'b0),
      .sticky_snan(sticky_snan3), .nan_cnt(nan_cnt3)
   );

   // ----------------------------------------------------- reference model
   // Class index straight from the IEEE-style field rules.
   function automatic logic [9:0] ref_class(input logic [31:0] x);
      int unsigned e = x[30:23];
      int unsigned m = x[22:0];
      bit          s = x[31];
      int          idx;
      if (e == 255)    idx = (m == 0) ? (s ? 0 : 7) : (x[22] ? 9 : 8);
      else if (e == 0) idx = (m == 0) ? (s ? 3 : 4) : (s ? 2 : 5);
      else             idx = s ? 1 : 6;
      return 10'd1 << idx;
   endfunction

   typedef struct {
      logic [39:0] cls;
      logic [3:0]  en;
   } beat_t;

   beat_t       mq[$];
   int          m_cnt    = 0;
   bit          m_sticky = 1'b0;
   bit          mon_en   = 1'b0;
   bit          m_acc, m_drn;
   beat_t       m_b;
   logic [9:0]  m_mask;

   // Sampled on the falling edge: compare the DUT against the model, then
   // apply the transfers that the next rising edge will perform.
   always @(negedge clk) begin
      if (rst) begin
         mq.delete();
         m_cnt    = 0;
         m_sticky = 1'b0;
      end else if (mon_en) begin
         m_acc = in_valid && (mq.size() < 2);
         m_drn = out_ready && (mq.size() > 0);
         check("mon_in_ready", in_ready, mq.size() < 2);
         check("mon_out_valid", out_valid, mq.size() > 0);
         check("mon_nan_cnt", nan_cnt, m_cnt);
         check("mon_sticky", sticky_snan, m_sticky);
         if (mq.size() > 0) begin
            check("mon_out_class", out_class, mq[0].cls);
            check("mon_out_lane_en", out_lane_en, mq[0].en);
         end
         if (clr) begin
            m_cnt    = 0;
            m_sticky = 1'b0;
         end
         if (m_acc) begin
            m_b.cls = '0;
            m_b.en  = in_lane_en;
            for (int l = 0; l < 4; l++) begin
               if (in_lane_en[l]) begin
                  m_mask = ref_class(in_data[l*32 +: 32]);
                  m_b.cls[l*10 +: 10] = m_mask;
                  if (m_mask[8] || m_mask[9]) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
                  if (m_mask[8]) m_sticky = 1'b1;
               end
            end
         end
         if (m_drn) void'(mq.pop_front());
         if (m_acc) mq.push_back(m_b);
      end
   end

   // ------------------------------------------------------------- helpers
   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [127:0] data, input logic [3:0] en);
      bit ok = 1'b0;
      in_data    = data;
      in_lane_en = en;
      in_valid   = 1'b1;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("send_accepted", ok, 1'b1);
   endtask

   function automatic logic [31:0] rand_fp();
      logic [7:0]  e;
      logic [22:0] m;
      case ($urandom_range(3))
         0:       e = 8'h00;
         1:       e = 8'hFF;
         default: e = 8'($urandom_range(254, 1));
      endcase
      case ($urandom_range(3))
         0:       m = '0;
         1:       m = 23'h400000 | 23'($urandom_range(7));
         2:       m = 23'($urandom) & 23'h3FFFFF;
         default: m = 23'($urandom);
      endcase
      return {1'($urandom), e, m};
   endfunction

   typedef struct {
      logic [127:0] data;
      logic [3:0]   en;
      logic [39:0]  cls;
      int           cnt;
      bit           sticky;
   } vec_t;

   vec_t vecs[4];

   localparam logic [127:0] BEAT_A = {4{32'h0000_0000}};
   localparam logic [127:0] BEAT_B = {4{32'h3F80_0000}};
   localparam logic [127:0] BEAT_C = {4{32'h7F80_0000}};

   // ---------------------------------------------------------------- test
   initial begin
      // Lanes listed 3..0; cnt/sticky are cumulative after each vector.
      vecs[0] = '{{32'h7F800001, 32'h7FC00000, 32'hFF800000, 32'h7F800000}, 4'b1111,
                  {10'h100, 10'h200, 10'h001, 10'h080}, 2, 1'b1};
      vecs[1] = '{{32'hBF800000, 32'h3F800000, 32'h80000000, 32'h00000001}, 4'b0111,
                  {10'h000, 10'h040, 10'h008, 10'h020}, 2, 1'b1};
      vecs[2] = '{{32'hFFC00000, 32'hFF800001, 32'h807FFFFF, 32'h00000000}, 4'b1111,
                  {10'h200, 10'h100, 10'h004, 10'h010}, 4, 1'b1};
      vecs[3] = '{{32'h80000001, 32'hBF800000, 32'h00800000, 32'h7F7FFFFF}, 4'b1010,
                  {10'h004, 10'h000, 10'h040, 10'h000}, 4, 1'b1};

      // Reset values
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_class", out_class, 40'h0);
      check("rst_out_lane_en", out_lane_en, 4'h0);
      check("rst_sticky", sticky_snan, 1'b0);
      check("rst_nan_cnt", nan_cnt, 16'h0);
      @(posedge clk); #1;
      mon_en = 1'b1;

      // Table-driven lane decode, one beat at a time
      out_ready = 1'b1;
      for (int v = 0; v < 4; v++) begin
         send(vecs[v].data, vecs[v].en);
         @(negedge clk);
         check("vec_out_valid", out_valid, 1'b1);
         check("vec_out_class", out_class, vecs[v].cls);
         check("vec_out_lane_en", out_lane_en, vecs[v].en);
         check("vec_nan_cnt", nan_cnt, vecs[v].cnt);
         check("vec_sticky", sticky_snan, vecs[v].sticky);
         @(posedge clk); #1;
      end

      // Backpressure: two beats fill the buffer, the third waits
      out_ready = 1'b0;
      send(BEAT_A, 4'hF);
      send(BEAT_B, 4'hF);
      in_data = BEAT_C; in_lane_en = 4'hF; in_valid = 1'b1;
      @(negedge clk);
      check("bp_in_ready_low", in_ready, 1'b0);
      check("bp_head_a", out_class, BEAT_A[39:0] | {4{10'h010}});
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_stable_a", out_class, {4{10'h010}});
      check("bp_still_full", in_ready, 1'b0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_no_comb_ready", in_ready, 1'b0);
      check("bp_out1_a", out_class, {4{10'h010}});
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_ready_recovered", in_ready, 1'b1);
      check("bp_out2_b", out_class, {4{10'h040}});
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("bp_out3_valid", out_valid, 1'b1);
      check("bp_out3_c", out_class, {4{10'h080}});
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_drained", out_valid, 1'b0);
      @(posedge clk); #1;

      // clr together with a single-qNaN beat
      clr = 1'b1;
      send({96'h0, 32'h7FC00000}, 4'b0001);
      clr = 1'b0;
      @(negedge clk);
      check("clr_nan_cnt", nan_cnt, 16'd1);
      check("clr_sticky", sticky_snan, 1'b0);
      @(posedge clk); #1;

      // Randomized traffic against the scoreboard
      for (int c = 0; c < 400; c++) begin
         in_valid   = 1'($urandom_range(1));
         in_data    = {rand_fp(), rand_fp(), rand_fp(), rand_fp()};
         in_lane_en = 4'($urandom);
         out_ready  = ($urandom_range(9) < 7);
         clr        = ($urandom_range(15) == 0);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      clr       = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // Reset with two entries buffered
      out_ready = 1'b0;
      send(BEAT_A, 4'hF);
      send(BEAT_B, 4'hF);
      #2 rst = 1'b1;
      #1;
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_in_ready", in_ready, 1'b1);
      check("midrst_out_class", out_class, 40'h0);
      check("midrst_nan_cnt", nan_cnt, 16'h0);
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      send({96'h0, 32'h7F800000}, 4'b0001);
      @(negedge clk);
      check("midrst_inf_valid", out_valid, 1'b1);
      check("midrst_inf_class", out_class, 40'h080);
      @(posedge clk); #1;

      // Counter saturation with CNT_W = 2
      in_data2 = {32'h0, 32'h0, 32'h7FC00000, 32'h7F800001}; in_lane_en2 = 4'hF; in_valid2 = 1'b1;
      @(posedge clk); #1;
      in_valid2 = 1'b0;
      @(negedge clk);
      check("sat_cnt_2", nan_cnt2, 2'd2);
      check("sat_sticky", sticky_snan2, 1'b1);
      for (int r = 0; r < 2; r++) begin
         @(posedge clk); #1;
         in_data2 = {4{32'h7FC00000}}; in_valid2 = 1'b1;
         @(posedge clk); #1;
         in_valid2 = 1'b0;
         @(negedge clk);
         check("sat_cnt_3", nan_cnt2, 2'd3);
      end
      @(posedge clk); #1;

      // Small unsigned format: 5-bit exponent, 10-bit mantissa
      begin
         logic [14:0] sm_in  [4];
         logic [9:0]  sm_exp [4];
         sm_in[0] = 15'h7E00; sm_exp[0] = 10'h200;
         sm_in[1] = 15'h0001; sm_exp[1] = 10'h020;
         sm_in[2] = 15'h7C00; sm_exp[2] = 10'h080;
         sm_in[3] = 15'h7C01; sm_exp[3] = 10'h100;
         for (int s = 0; s < 4; s++) begin
            in_data3 = sm_in[s]; in_valid3 = 1'b1;
            @(posedge clk); #1;
            in_valid3 = 1'b0;
            @(negedge clk);
            check("small_valid", out_valid3, 1'b1);
            check("small_class", out_class3, sm_exp[s]);
            @(posedge clk); #1;
         end
         check("small_nan_cnt", nan_cnt3, 16'd2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_fp_classify_pipe
